display_to_matrix_idx: RTL and testbench

// Inverse of the matrix-index-to-display mapping: converts the VGA raster

---
 rtl/display_to_matrix_idx.sv | 91 +++++++++
 tb/tb_display_to_matrix_idx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/display_to_matrix_idx.sv
// Maps a VGA raster position to its 80x50 game-matrix cell, the pixel offset
// inside the 16x16 cell and the linear matrix address, through a 2-beat pipeline.
module display_to_matrix_idx #(
    parameter int H_VISIBLE_START = 336,
    parameter int V_VISIBLE_START = 27,
    parameter int H_VISIBLE       = 1280,
    parameter int V_VISIBLE       = 800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [10:0] h_cnt,
    input  logic [9:0]  v_cnt,
    output logic [6:0]  cell_x,
    output logic [5:0]  cell_y,
    output logic [3:0]  sub_x,
    output logic [3:0]  sub_y,
    output logic [11:0] cell_addr,
    output logic        in_visible,
    output logic        cell_start,
    output logic        frame_start
);

    // pix_en is a bare strobe with no back-pressure: every register in both
    // stages advances on a clock edge where pix_en=1 and holds otherwise.

    logic        vis;
    logic [10:0] dx;
    logic [9:0]  dy;

    logic        s1_vis;
    logic [6:0]  s1_x;
    logic [5:0]  s1_y;
    logic [3:0]  s1_sx;
    logic [3:0]  s1_sy;

    // Window test on raw counts so positions left/above the window never wrap.
    always_comb begin
        vis = (h_cnt >= 11'(H_VISIBLE_START)) &&
              (h_cnt <  11'(H_VISIBLE_START + H_VISIBLE)) &&
              (v_cnt >= 10'(V_VISIBLE_START)) &&
              (v_cnt <  10'(V_VISIBLE_START + V_VISIBLE));
        dx = 11'd0;
        dy = 10'd0;
        if (vis) begin
            dx = h_cnt - 11'(H_VISIBLE_START);
            dy = v_cnt - 10'(V_VISIBLE_START);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vis <= 1'b0;
            s1_x   <= 7'd0;
            s1_y   <= 6'd0;
            s1_sx  <= 4'd0;
            s1_sy  <= 4'd0;
        end else if (pix_en) begin
            s1_vis <= vis;
            s1_x   <= dx[10:4];
            s1_y   <= dy[9:4];
            s1_sx  <= dx[3:0];
            s1_sy  <= dy[3:0];
        end
    end

    // y*80 + x as two shifted copies of y plus x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_x      <= 7'd0;
            cell_y      <= 6'd0;
            sub_x       <= 4'd0;
            sub_y       <= 4'd0;
            cell_addr   <= 12'd0;
            in_visible  <= 1'b0;
            cell_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            cell_x      <= s1_x;
            cell_y      <= s1_y;
            sub_x       <= s1_sx;
            sub_y       <= s1_sy;
            cell_addr   <= {s1_y, 6'b0} + {2'b0, s1_y, 4'b0} + {5'b0, s1_x};
            in_visible  <= s1_vis;
            cell_start  <= s1_vis && (s1_sx == 4'd0);
            frame_start <= s1_vis && (s1_x == 7'd0) && (s1_y == 6'd0) &&
                           (s1_sx == 4'd0) && (s1_sy == 4'd0);
        end
    end

endmodule

// File: tb/tb_display_to_matrix_idx.sv
// Directed bench for display_to_matrix_idx: reset, corner cells, window edges,
// and an h sweep with a continuous and a gapped pixel strobe.
module tb_display_to_matrix_idx;

    logic        clk;
    logic        rst_n;
    logic        pix_en;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [6:0]  cell_x;
    logic [5:0]  cell_y;
    logic [3:0]  sub_x;
    logic [3:0]  sub_y;
    logic [11:0] cell_addr;
    logic        in_visible;
    logic        cell_start;
    logic        frame_start;

    int tests_run = 0;
    int tests_failed = 0;

    logic [10:0] exp_q[$];

    display_to_matrix_idx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .sub_x       (sub_x),
        .sub_y       (sub_y),
        .cell_addr   (cell_addr),
        .in_visible  (in_visible),
        .cell_start  (cell_start),
        .frame_start (frame_start)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v);
        h_cnt  = h;
        v_cnt  = v;
        pix_en = 1'b1;
        step();
        step();
    endtask

    // scoreboard check on the full output bundle
    task automatic check(input string tag, input logic [6:0] ex, input logic [5:0] ey,
                         input logic [3:0] esx, input logic [3:0] esy, input logic [11:0] ea,
                         input logic ev, input logic ecs, input logic efs);
        logic [35:0] obs;
        logic [35:0] expv;
        obs  = {cell_x, cell_y, sub_x, sub_y, cell_addr, in_visible, cell_start, frame_start};
        expv = {ex, ey, esx, esy, ea, ev, ecs, efs};
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: got x=%0d y=%0d sx=%0d sy=%0d addr=%0d vis=%b cs=%b fs=%b, want x=%0d y=%0d sx=%0d sy=%0d addr=%0d vis=%b cs=%b fs=%b",
                   tag, cell_x, cell_y, sub_x, sub_y, cell_addr, in_visible, cell_start, frame_start,
                   ex, ey, esx, esy, ea, ev, ecs, efs);
        end
    endtask

    task automatic check_h(input string tag, input logic [10:0] h);
        logic [10:0] d;
        d = h - 11'd336;
        check(tag, d[10:4], 6'd0, d[3:0], 4'd0, {5'b0, d[10:4]}, 1'b1, d[3:0] == 4'd0,
              d == 11'd0);
    endtask

    initial begin
        logic [10:0] held;
        logic [10:0] h;
        rst_n  = 1'b0;
        pix_en = 1'b1;
        h_cnt  = 11'd500;
        v_cnt  = 10'd300;
        #2;
        check("reset_initial", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("reset_held", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        drive(11'd1615, 10'd826);
        check("corner_79_49", 7'd79, 6'd49, 4'd15, 4'd15, 12'd3999, 1'b1, 1'b0, 1'b0);

        // mid-frame reset clears outputs without a clock edge
        h_cnt = 11'd500;
        v_cnt = 10'd300;
        #1 rst_n = 1'b0;
        #1;
        check("reset_async", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        step();
        #2 rst_n = 1'b1;
        step();
        check("post_reset_beat1", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("post_reset_beat2", 7'd10, 6'd17, 4'd4, 4'd1, 12'd1370, 1'b1, 1'b0, 1'b0);

        drive(11'd336, 10'd27);
        check("origin", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b1, 1'b1, 1'b1);
        drive(11'd1615, 10'd826);
        check("corner_again", 7'd79, 6'd49, 4'd15, 4'd15, 12'd3999, 1'b1, 1'b0, 1'b0);
        drive(11'd335, 10'd100);
        check("left_of_window", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(11'd1616, 10'd100);
        check("right_of_window", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(11'd400, 10'd827);
        check("below_window", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(11'd400, 10'd26);
        check("above_window", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(11'd423, 10'd77);
        check("mid_cell", 7'd5, 6'd3, 4'd7, 4'd2, 12'd245, 1'b1, 1'b0, 1'b0);
        drive(11'd416, 10'd77);
        check("cell_start", 7'd5, 6'd3, 4'd0, 4'd2, 12'd245, 1'b1, 1'b1, 1'b0);
        drive(11'd2047, 10'd1023);
        check("max_counts", 7'd0, 6'd0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b0, 1'b0);

        // raster jump straight from out-of-window to a visible cell
        drive(11'd1000, 10'd500);
        check("jump", 7'd41, 6'd29, 4'd8, 4'd9, 12'd2361, 1'b1, 1'b0, 1'b0);

        // sweep with pix_en every cycle: output trails input by two beats
        v_cnt  = 10'd27;
        pix_en = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 1280; i++) begin
            h_cnt = 11'(336 + i);
            exp_q.push_back(h_cnt);
            step();
            if (exp_q.size() == 2) check_h("sweep_full", exp_q.pop_front());
        end

        // gapped strobe: one beat then two idle cycles with scrambled inputs
        exp_q.delete();
        held = 11'd0;
        for (int i = 0; i < 200; i++) begin
            h = 11'(336 + i);
            h_cnt  = h;
            v_cnt  = 10'd27;
            pix_en = 1'b1;
            exp_q.push_back(h);
            step();
            if (exp_q.size() == 2) begin
                held = exp_q.pop_front();
                check_h("sweep_gap", held);
            end
            for (int k = 0; k < 2; k++) begin
                pix_en = 1'b0;
                h_cnt  = 11'($urandom_range(0, 2047));
                v_cnt  = 10'($urandom_range(0, 1023));
                step();
                if (i > 0) check_h("sweep_hold", held);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
